ctrl_multicycle_rv32: RTL and testbench

CTRL_MULTICYCLE_RV32 -- requirements
Module: ctrl_multicycle_rv32

---
 rtl/ctrl_multicycle_rv32.sv | 259 +++++++++++++++++++++++++
 tb/tb_ctrl_multicycle_rv32.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_multicycle_rv32.sv
// Multicycle RV32 control unit: Moore FSM sequencing fetch, decode, memory,
// ALU and branch/jump steps, with a memory-wait timeout that traps.
module ctrl_multicycle_rv32 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  ImmSel,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  result_src,
  output logic        addr_src,
  output logic        illegal,
  output logic [3:0]  state_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [1:0] IMM_I  = 2'b00;
  localparam logic [1:0] IMM_S  = 2'b01;
  localparam logic [1:0] IMM_SB = 2'b10;
  localparam logic [1:0] IMM_J  = 2'b11;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC_R = 4'd7,
    S_EXEC_I = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11,
    S_TRAP   = 4'd15
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             wait_st_c;
  logic             timeout_c;
  logic             unused_instr_bits;

  assign opcode  = instr_d[6:0];
  assign funct3  = instr_d[14:12];
  assign state_o = 4'(state_q);
  assign unused_instr_bits = ^{instr_d[31:15], instr_d[11:7]};

  // Memory wait states are the only ones that can stall and time out.
  assign wait_st_c = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout_c = wait_st_c && !mem_ready && (cnt_q == CNT_LAST);

  // State register and wait counter; counter restarts whenever the state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (wait_st_c && !mem_ready) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next state plus Moore outputs; FETCH and BRANCH strobes are input-qualified.
  always_comb begin
    state_d    = state_q;
    ImmSel     = IMM_I;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_ADD;
    result_src = RES_ALUOUT;
    addr_src   = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          result_src = RES_ALU;
          state_d    = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_src_a = SRC_A_OLDPC;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
        if (opcode == OP_BRANCH) begin
          ImmSel = IMM_SB;
        end else if (opcode == OP_JAL) begin
          ImmSel = IMM_J;
        end
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH: begin
            if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) begin
              state_d = S_BRANCH;
            end else begin
              state_d = S_TRAP;
            end
          end
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
        if (opcode == OP_STORE) begin
          ImmSel  = IMM_S;
          state_d = S_MEMWR;
        end else begin
          ImmSel  = IMM_I;
          state_d = S_MEMRD;
        end
      end

      S_MEMRD: begin
        mem_req  = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEMWR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        addr_src = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end

      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_FUNCT;
        state_d   = S_ALUWB;
      end

      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_FUNCT;
        ImmSel    = IMM_I;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write   = (funct3 == F3_BEQ) ? zero : !zero;
        state_d    = S_FETCH;
      end

      S_JAL: begin
        alu_src_a  = SRC_A_OLDPC;
        alu_src_b  = SRC_B_FOUR;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end

      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_TRAP;
      end
    endcase

    // A stalled request that hits the limit overrides the normal transition.
    if (timeout_c) begin
      state_d = S_TRAP;
    end
  end

endmodule

// File: tb/tb_ctrl_multicycle_rv32.sv
// Self-checking bench for ctrl_multicycle_rv32: per-cycle expected output
// vectors from a spec-table model go through a scoreboard queue.
module tb_ctrl_multicycle_rv32;

  localparam int ST_IDLE   = 0;
  localparam int ST_FETCH  = 1;
  localparam int ST_DECODE = 2;
  localparam int ST_MEMADR = 3;
  localparam int ST_MEMRD  = 4;
  localparam int ST_MEMWB  = 5;
  localparam int ST_MEMWR  = 6;
  localparam int ST_EXEC_R = 7;
  localparam int ST_EXEC_I = 8;
  localparam int ST_ALUWB  = 9;
  localparam int ST_BRANCH = 10;
  localparam int ST_JAL    = 11;
  localparam int ST_TRAP   = 15;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_d;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  imm_sel;
  logic        ir_write, pc_write, reg_write, mem_req, mem_we;
  logic [1:0]  alu_src_a, alu_src_b, alu_op, result_src;
  logic        addr_src, illegal;
  logic [3:0]  state_o;
  logic [20:0] obs_w;

  int total = 0;
  int bad   = 0;
  logic [20:0] exp_q [$];
  int st_q [$];
  int rd_q [$];

  ctrl_multicycle_rv32 #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .zero(zero), .mem_ready(mem_ready),
    .ImmSel(imm_sel), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .addr_src(addr_src), .illegal(illegal),
    .state_o(state_o)
  );

  assign obs_w = {state_o, illegal, imm_sel, ir_write, pc_write, reg_write, mem_req, mem_we,
                  alu_src_a, alu_src_b, alu_op, result_src, addr_src};

  always #5 clk = ~clk;

  // Output table written straight from the state descriptions.
  function automatic logic [20:0] spec_out(input logic [3:0] st, input logic [31:0] ins,
                                           input logic rdy, input logic z);
    logic il, irw, pcw, rw, mr, we, as;
    logic [1:0] imm, a, b, op, res;
    logic [6:0] opc;
    opc = ins[6:0];
    {il, irw, pcw, rw, mr, we, as} = 7'b0;
    {imm, a, b, op, res} = 10'b0;
    case (st)
      4'd1:  begin mr = 1'b1; b = 2'b10; if (rdy) begin irw = 1'b1; pcw = 1'b1; res = 2'b10; end end
      4'd2:  begin a = 2'b01; b = 2'b01;
                   imm = (opc == 7'b1100011) ? 2'b10 : (opc == 7'b1101111) ? 2'b11 : 2'b00; end
      4'd3:  begin a = 2'b10; b = 2'b01; imm = (opc == 7'b0100011) ? 2'b01 : 2'b00; end
      4'd4:  begin mr = 1'b1; as = 1'b1; end
      4'd5:  begin res = 2'b01; rw = 1'b1; end
      4'd6:  begin mr = 1'b1; we = 1'b1; as = 1'b1; end
      4'd7:  begin a = 2'b10; b = 2'b00; op = 2'b10; end
      4'd8:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      4'd9:  begin rw = 1'b1; end
      4'd10: begin a = 2'b10; op = 2'b01; pcw = (ins[14:12] == 3'b000) ? z : !z; end
      4'd11: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      4'd15: begin il = 1'b1; end
      default: ;
    endcase
    return {st, il, imm, irw, pcw, rw, mr, we, a, b, op, res, as};
  endfunction

  task automatic add(input int st, input int rd, input int n);
    for (int k = 0; k < n; k++) begin
      st_q.push_back(st);
      rd_q.push_back(rd);
    end
  endtask

  // Holds reset across two edges, releases it 1 time unit after a rising edge.
  task automatic do_reset(input logic [31:0] ins, input logic z);
    rst_n = 1'b0; mem_ready = 1'b0; zero = z; instr_d = ins;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    rst_n = 1'b0; mem_ready = 1'b1; instr_d = 32'h00450693;
    #2;
    exp_q.push_back(spec_out(4'd0, instr_d, 1'b1, 1'b0));
    e = exp_q.pop_front(); total++;
    if (obs_w !== e) begin bad++; $display("FAIL reset_initial: dut=%h exp=%h", obs_w, e); end
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(spec_out(4'd0, instr_d, 1'b1, 1'b0));
    e = exp_q.pop_front(); total++;
    if (obs_w !== e) begin bad++; $display("FAIL reset_held_clocked: dut=%h exp=%h", obs_w, e); end
  endtask

  task automatic test_addi();
    logic [20:0] e; int st, rd, n = 0;
    do_reset(32'h00450693, 1'b0);
    add(ST_IDLE, 0, 1); add(ST_FETCH, 0, 1); add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1);
    add(ST_EXEC_I, 0, 1); add(ST_ALUWB, 0, 1); add(ST_FETCH, 0, 1);
    while (st_q.size() != 0) begin
      st = st_q.pop_front(); rd = rd_q.pop_front();
      mem_ready = (rd != 0);
      exp_q.push_back(spec_out(4'(st), instr_d, mem_ready, zero));
      #2; e = exp_q.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL addi cyc%0d: dut=%h exp=%h", n, obs_w, e); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_exec_r_load();
    logic [20:0] e; int st, rd, n = 0;
    do_reset(32'h00B50533, 1'b0);
    add(ST_IDLE, 0, 1); add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1); add(ST_EXEC_R, 0, 1);
    add(ST_ALUWB, 0, 1); add(ST_FETCH, 0, 1);
    while (st_q.size() != 0) begin
      st = st_q.pop_front(); rd = rd_q.pop_front();
      mem_ready = (rd != 0);
      exp_q.push_back(spec_out(4'(st), instr_d, mem_ready, zero));
      #2; e = exp_q.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL exec_r cyc%0d: dut=%h exp=%h", n, obs_w, e); end
      n++; @(posedge clk); #1;
    end
    do_reset(32'h00052503, 1'b0);
    add(ST_IDLE, 0, 1); add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1); add(ST_MEMADR, 0, 1);
    add(ST_MEMRD, 0, 2); add(ST_MEMRD, 1, 1); add(ST_MEMWB, 0, 1); add(ST_FETCH, 0, 1);
    n = 0;
    while (st_q.size() != 0) begin
      st = st_q.pop_front(); rd = rd_q.pop_front();
      mem_ready = (rd != 0);
      exp_q.push_back(spec_out(4'(st), instr_d, mem_ready, zero));
      #2; e = exp_q.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL load cyc%0d: dut=%h exp=%h", n, obs_w, e); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    logic [20:0] e; int st, rd, n = 0;
    do_reset(32'h00B50423, 1'b0);
    add(ST_IDLE, 0, 1); add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1); add(ST_MEMADR, 0, 1);
    add(ST_MEMWR, 0, 2); add(ST_MEMWR, 1, 1); add(ST_FETCH, 0, 1);
    while (st_q.size() != 0) begin
      st = st_q.pop_front(); rd = rd_q.pop_front();
      mem_ready = (rd != 0);
      exp_q.push_back(spec_out(4'(st), instr_d, mem_ready, zero));
      #2; e = exp_q.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL store cyc%0d: dut=%h exp=%h", n, obs_w, e); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [20:0] e; int st, rd, n;
    logic [31:0] ins [4] = '{32'hFE551CE3, 32'hFE551CE3, 32'h00000063, 32'h00000063};
    logic        zs  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int r = 0; r < 4; r++) begin
      do_reset(ins[r], zs[r]);
      add(ST_IDLE, 0, 1); add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1); add(ST_BRANCH, 0, 1);
      add(ST_FETCH, 0, 1);
      n = 0;
      while (st_q.size() != 0) begin
        st = st_q.pop_front(); rd = rd_q.pop_front();
        mem_ready = (rd != 0);
        exp_q.push_back(spec_out(4'(st), instr_d, mem_ready, zero));
        #2; e = exp_q.pop_front(); total++;
        if (obs_w !== e) begin bad++; $display("FAIL branch run%0d cyc%0d: dut=%h exp=%h", r, n, obs_w, e); end
        n++; @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jal();
    logic [20:0] e; int st, rd, n = 0;
    do_reset(32'h0020006F, 1'b0);
    add(ST_IDLE, 0, 1); add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1); add(ST_JAL, 0, 1);
    add(ST_ALUWB, 0, 1); add(ST_FETCH, 0, 1);
    while (st_q.size() != 0) begin
      st = st_q.pop_front(); rd = rd_q.pop_front();
      mem_ready = (rd != 0);
      exp_q.push_back(spec_out(4'(st), instr_d, mem_ready, zero));
      #2; e = exp_q.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL jal cyc%0d: dut=%h exp=%h", n, obs_w, e); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [20:0] e; int st, rd, n;
    logic [31:0] ins [2] = '{32'h0000007F, 32'h00002063};
    for (int r = 0; r < 2; r++) begin
      do_reset(ins[r], 1'b0);
      add(ST_IDLE, 0, 1); add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1);
      for (int k = 0; k < 20; k++) add(ST_TRAP, k % 2, 1);
      n = 0;
      while (st_q.size() != 0) begin
        st = st_q.pop_front(); rd = rd_q.pop_front();
        mem_ready = (rd != 0);
        exp_q.push_back(spec_out(4'(st), instr_d, mem_ready, zero));
        #2; e = exp_q.pop_front(); total++;
        if (obs_w !== e) begin bad++; $display("FAIL illegal run%0d cyc%0d: dut=%h exp=%h", r, n, obs_w, e); end
        n++; @(posedge clk); #1;
      end
    end
  endtask

  // Run 0: fetch stalls the full limit; run 1: ready on the last allowed cycle;
  // run 2: memory read stalls the full limit.
  task automatic test_timeout();
    logic [20:0] e; int st, rd, n;
    for (int r = 0; r < 3; r++) begin
      do_reset((r == 2) ? 32'h00052503 : 32'h00450693, 1'b0);
      add(ST_IDLE, 0, 1);
      if (r == 0) begin
        add(ST_FETCH, 0, 16); add(ST_TRAP, 1, 3);
      end else if (r == 1) begin
        add(ST_FETCH, 0, 15); add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1); add(ST_EXEC_I, 0, 1);
      end else begin
        add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1); add(ST_MEMADR, 0, 1);
        add(ST_MEMRD, 0, 16); add(ST_TRAP, 1, 2);
      end
      n = 0;
      while (st_q.size() != 0) begin
        st = st_q.pop_front(); rd = rd_q.pop_front();
        mem_ready = (rd != 0);
        exp_q.push_back(spec_out(4'(st), instr_d, mem_ready, zero));
        #2; e = exp_q.pop_front(); total++;
        if (obs_w !== e) begin bad++; $display("FAIL timeout run%0d cyc%0d: dut=%h exp=%h", r, n, obs_w, e); end
        n++; @(posedge clk); #1;
      end
    end
  endtask

  // Two long fetch stalls in a row must each get a fresh wait budget.
  task automatic test_back_to_back();
    logic [20:0] e; int st, rd, n = 0;
    do_reset(32'h00450693, 1'b0);
    add(ST_IDLE, 0, 1); add(ST_FETCH, 0, 10); add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1);
    add(ST_EXEC_I, 0, 1); add(ST_ALUWB, 0, 1); add(ST_FETCH, 0, 15); add(ST_FETCH, 1, 1);
    add(ST_DECODE, 0, 1);
    while (st_q.size() != 0) begin
      st = st_q.pop_front(); rd = rd_q.pop_front();
      mem_ready = (rd != 0);
      exp_q.push_back(spec_out(4'(st), instr_d, mem_ready, zero));
      #2; e = exp_q.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL back_to_back cyc%0d: dut=%h exp=%h", n, obs_w, e); end
      n++; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [20:0] e; int st, rd, n = 0;
    do_reset(32'h00B50423, 1'b0);
    add(ST_IDLE, 0, 1); add(ST_FETCH, 1, 1); add(ST_DECODE, 0, 1); add(ST_MEMADR, 0, 1);
    add(ST_MEMWR, 0, 2);
    while (st_q.size() != 0) begin
      st = st_q.pop_front(); rd = rd_q.pop_front();
      mem_ready = (rd != 0);
      exp_q.push_back(spec_out(4'(st), instr_d, mem_ready, zero));
      #2; e = exp_q.pop_front(); total++;
      if (obs_w !== e) begin bad++; $display("FAIL reset_mid cyc%0d: dut=%h exp=%h", n, obs_w, e); end
      n++; @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    exp_q.push_back(spec_out(4'(ST_MEMWR), instr_d, 1'b0, zero));
    #2; e = exp_q.pop_front(); total++;
    if (obs_w !== e) begin bad++; $display("FAIL reset_mid pre_assert: dut=%h exp=%h", obs_w, e); end
    rst_n = 1'b0;
    exp_q.push_back(spec_out(4'(ST_IDLE), instr_d, 1'b0, zero));
    #1; e = exp_q.pop_front(); total++;
    if (obs_w !== e) begin bad++; $display("FAIL reset_mid async_clear: dut=%h exp=%h", obs_w, e); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(spec_out(4'(ST_IDLE), instr_d, 1'b0, zero));
    #2; e = exp_q.pop_front(); total++;
    if (obs_w !== e) begin bad++; $display("FAIL reset_mid release_idle: dut=%h exp=%h", obs_w, e); end
    @(posedge clk); #1;
    exp_q.push_back(spec_out(4'(ST_FETCH), instr_d, 1'b0, zero));
    #2; e = exp_q.pop_front(); total++;
    if (obs_w !== e) begin bad++; $display("FAIL reset_mid first_fetch: dut=%h exp=%h", obs_w, e); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; instr_d = '0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_exec_r_load();
    test_store();
    test_branch();
    test_jal();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: sim time %0t exceeded limit 500000", $time);
    $fatal(1);
  end

endmodule
